jump_tick_scheduler: RTL and testbench

Time-multiplexed controller for jump-counter frequency division: one shared 33-bit accumulate-and-carry datapath serves NCH independent tick channels in a fixed round-robin slot order. Each channel has its own programmable jump value and enable, written through a valid/ready configuration port. The block sits between the system clock and the blocks that need several slow strobes: debouncers, display refresh, and blink timers.

---
 rtl/jump_sched_pkg.sv | 25 ++
 rtl/jump_acc_core.sv | 28 ++
 rtl/jump_tick_scheduler.sv | 139 +++++++++++++
 tb/tb_jump_tick_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_sched_pkg.sv
// jump_sched_pkg
//   Shared types and constants for jump_tick_scheduler.
//   Contents:
//     ACC_W        accumulator / jump width (carry is bit ACC_W of the sum)
//     CH_W_MAX     channel-index width wide enough for the largest channel count (16)
//     cfg_state_e  configuration FSM states
//     pend_wr_t    configuration write held while waiting for the target slot
//   Optional feature macro used by the top: PHASE_SYNC_EN (not referenced here).
package jump_sched_pkg;

   localparam int unsigned ACC_W    = 32;
   localparam int unsigned CH_W_MAX = 4;

   typedef enum logic {
      CFG_READY = 1'b0,
      CFG_PEND  = 1'b1
   } cfg_state_e;

   typedef struct packed {
      logic [CH_W_MAX-1:0] ch;
      logic [ACC_W-1:0]    jump;
      logic                en;
   } pend_wr_t;

endpackage

// File: rtl/jump_acc_core.sv
// jump_acc_core
//   Shared combinational accumulate-and-carry stage. One instance serves all
//   channels; the caller selects the serviced channel's operands.
//   Ports:
//     acc_i    current accumulator of the serviced channel
//     jump_i   jump value of the serviced channel
//     en_i     channel enable; when low the accumulator passes through, no carry
//     sum_o    low Width bits of acc_i + jump_i (or acc_i when disabled)
//     carry_o  bit Width of the sum (0 when disabled)
module jump_acc_core #(
   parameter int unsigned Width = 32
) (
   input  logic [Width-1:0] acc_i,
   input  logic [Width-1:0] jump_i,
   input  logic             en_i,
   output logic [Width-1:0] sum_o,
   output logic             carry_o
);

   always_comb begin
      if (en_i) begin
         {carry_o, sum_o} = {1'b0, acc_i} + {1'b0, jump_i};
      end else begin
         {carry_o, sum_o} = {1'b0, acc_i};
      end
   end

endmodule

// File: rtl/jump_tick_scheduler.sv
// jump_tick_scheduler
//   Time-multiplexed jump-counter divider: one shared adder services NCH tick
//   channels in round-robin slot order, each channel once every NCH cycles.
//   Per-channel jump/enable are written through a valid/ready port; a write is
//   held until the target channel's own slot, where it replaces that service.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     sync       (PHASE_SYNC_EN only) clears every accumulator and the slot counter
//     cfg_valid  configuration write request
//     cfg_ready  configuration port can accept a write
//     cfg_ch     target channel
//     cfg_jump   new jump value
//     cfg_en     new channel enable
//     tick       per-channel one-cycle strobe, registered
//   Build option: define PHASE_SYNC_EN to add the sync input.
module jump_tick_scheduler
   import jump_sched_pkg::*;
#(
   parameter int unsigned NCH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
`ifdef PHASE_SYNC_EN
   input  logic                   sync,
`endif
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [$clog2(NCH)-1:0] cfg_ch,
   input  logic [ACC_W-1:0]       cfg_jump,
   input  logic                   cfg_en,
   output logic [NCH-1:0]         tick
);

   localparam int unsigned CH_W = $clog2(NCH);

   logic [CH_W-1:0]  slot_q, slot_d;
   logic [ACC_W-1:0] acc_q  [NCH];
   logic [ACC_W-1:0] acc_d  [NCH];
   logic [ACC_W-1:0] jump_q [NCH];
   logic [ACC_W-1:0] jump_d [NCH];
   logic [NCH-1:0]   en_q, en_d;
   logic [NCH-1:0]   tick_q, tick_d;
   cfg_state_e       state_q, state_d;
   pend_wr_t         pend_q, pend_d;

   logic [ACC_W-1:0] sum;
   logic             carry;
   logic             load_hit;

   jump_acc_core #(
      .Width(ACC_W)
   ) u_core (
      .acc_i  (acc_q[slot_q]),
      .jump_i (jump_q[slot_q]),
      .en_i   (en_q[slot_q]),
      .sum_o  (sum),
      .carry_o(carry)
   );

   // A pending write lands only in its own channel's slot.
   assign load_hit  = (state_q == CFG_PEND) && (pend_q.ch == CH_W_MAX'(slot_q));
   assign cfg_ready = (state_q == CFG_READY);
   assign tick      = tick_q;

   always_comb begin
      // NCH is a power of two, so the slot counter wraps on overflow.
      slot_d  = slot_q + 1'b1;
      acc_d   = acc_q;
      jump_d  = jump_q;
      en_d    = en_q;
      tick_d  = '0;
      state_d = state_q;
      pend_d  = pend_q;

      if (load_hit) begin
         // The load replaces this slot's service: phase restarts, no carry.
         acc_d[slot_q]  = '0;
         jump_d[slot_q] = pend_q.jump;
         en_d[slot_q]   = pend_q.en;
      end else begin
         acc_d[slot_q]  = sum;
         tick_d[slot_q] = carry;
      end

      case (state_q)
         CFG_READY: begin
            if (cfg_valid) begin
               pend_d.ch   = CH_W_MAX'(cfg_ch);
               pend_d.jump = cfg_jump;
               pend_d.en   = cfg_en;
               state_d     = CFG_PEND;
            end
         end
         CFG_PEND: begin
            if (load_hit) begin
               state_d = CFG_READY;
            end
         end
         default: state_d = CFG_READY;
      endcase

`ifdef PHASE_SYNC_EN
      // Sync overrides accumulators and slot; a coinciding load still updates jump/en.
      if (sync) begin
         for (int i = 0; i < NCH; i++) begin
            acc_d[i] = '0;
         end
         slot_d = '0;
         tick_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= '0;
         en_q    <= '0;
         tick_q  <= '0;
         state_q <= CFG_READY;
         pend_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= '0;
            jump_q[i] <= '0;
         end
      end else begin
         slot_q  <= slot_d;
         en_q    <= en_d;
         tick_q  <= tick_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= acc_d[i];
            jump_q[i] <= jump_d[i];
         end
      end
   end

endmodule

// File: tb/tb_jump_tick_scheduler.sv
// tb_jump_tick_scheduler
//   Self-checking bench for jump_tick_scheduler (NCH=4). A behavioural model
//   (slot = cycles since reset mod NCH, 64-bit sums for carry, one pending
//   write record) predicts tick and cfg_ready every cycle; directed phases
//   add explicit timing checks. Build option PHASE_SYNC_EN adds the sync test.
module tb_jump_tick_scheduler;

   localparam int NCH = 4;
   localparam longint unsigned MOD = 64'h1_0000_0000;

   logic           clk;
   logic           rst_n;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [1:0]     cfg_ch;
   logic [31:0]    cfg_jump;
   logic           cfg_en;
   logic [NCH-1:0] tick;
`ifdef PHASE_SYNC_EN
   logic           sync;
`endif

   jump_tick_scheduler #(
      .NCH(NCH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef PHASE_SYNC_EN
      .sync     (sync),
`endif
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_jump (cfg_jump),
      .cfg_en   (cfg_en),
      .tick     (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   longint unsigned m_acc  [NCH];
   longint unsigned m_jump [NCH];
   bit              m_en   [NCH];
   int              m_slot;
   bit              m_pend;
   int              m_pch;
   longint unsigned m_pjump;
   bit              m_pen;
   logic [NCH-1:0]  m_tick;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i]  = 0;
         m_jump[i] = 0;
         m_en[i]   = 0;
      end
      m_slot = 0;
      m_pend = 0;
      m_tick = '0;
   endtask

   // Applies one rising edge to the model using the inputs present at that edge.
   task automatic model_edge();
      int              s;
      bit              was_ready;
      bit              sy;
      longint unsigned total;
      logic [NCH-1:0]  t;
      s         = m_slot;
      was_ready = !m_pend;
      sy        = 1'b0;
      t         = '0;
`ifdef PHASE_SYNC_EN
      sy = sync;
`endif
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_pend && m_pch == s) begin
         m_acc[s]  = 0;
         m_jump[s] = m_pjump;
         m_en[s]   = m_pen;
         m_pend    = 0;
      end else if (m_en[s]) begin
         total = m_acc[s] + m_jump[s];
         if (total >= MOD) t[s] = 1'b1;
         m_acc[s] = total % MOD;
      end
      if (was_ready && cfg_valid) begin
         m_pend  = 1;
         m_pch   = int'(cfg_ch);
         m_pjump = longint'(cfg_jump);
         m_pen   = cfg_en;
      end
      m_slot = (s + 1) % NCH;
      if (sy) begin
         for (int i = 0; i < NCH; i++) m_acc[i] = 0;
         m_slot = 0;
         t      = '0;
      end
      m_tick = t;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("tick", tick, m_tick);
      check_eq("cfg_ready", cfg_ready, !m_pend);
      check_eq("tick_onehot0", $countones(tick) <= 1, 1);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_tick", tick, 0);
      check_eq("rst_ready", cfg_ready, 1);
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   // Presents a write and steps until the edge that accepts it.
   task automatic write_cfg(input int ch, input logic [31:0] jump, input bit en,
                            input bit hold, output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_jump  = jump;
      cfg_en    = en;
      for (int k = 0; k < 3 * NCH && !done; k++) begin
         done = cfg_ready;
         if (!done) waits++;
         step();
      end
      check_eq("accept", done, 1);
      if (!hold) cfg_valid = 1'b0;
   endtask

   // Steps until cfg_ready returns, i.e. just past the load edge.
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!cfg_ready && n < 3 * NCH);
      check_eq("load_latency_in_range", (n >= 1) && (n <= NCH), 1);
   endtask

   task automatic wait_tick(input int ch, input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick[ch] && n < budget);
   endtask

   int n, d, w, cnt;

   initial begin
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_jump  = '0;
      cfg_en    = 1'b0;
`ifdef PHASE_SYNC_EN
      sync      = 1'b0;
`endif
      apply_reset();

      // Idle: no ticks for 100 cycles
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tick != 0) cnt++;
      end
      check_eq("idle_no_tick", cnt, 0);

      // ch0 half-range jump: tick every 2*NCH cycles
      write_cfg(0, 32'h8000_0000, 1'b1, 1'b0, w);
      wait_ready(n);
      wait_tick(0, 20, d);
      check_eq("ch0_first_tick", d, 8);
      wait_tick(0, 20, d);
      check_eq("ch0_period", d, 8);

      // ch2 quarter-range jump: tick every 4*NCH cycles
      write_cfg(2, 32'h4000_0000, 1'b1, 1'b0, w);
      wait_ready(n);
      wait_tick(2, 40, d);
      check_eq("ch2_first_tick", d, 16);
      wait_tick(2, 40, d);
      check_eq("ch2_period", d, 16);

      // Back-to-back writes with cfg_valid held
      write_cfg(1, 32'h2000_0000, 1'b1, 1'b1, w);
      write_cfg(3, 32'h1000_0000, 1'b1, 1'b0, w);
      check_eq("b2b_wait_range", (w >= 1) && (w <= NCH), 1);
      wait_ready(n);

      // Disable ch0, then re-enable with the same jump
      write_cfg(0, 32'h8000_0000, 1'b0, 1'b0, w);
      wait_ready(n);
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (tick[0]) cnt++;
      end
      check_eq("ch0_disabled_no_tick", cnt, 0);
      write_cfg(0, 32'h8000_0000, 1'b1, 1'b0, w);
      wait_ready(n);
      wait_tick(0, 20, d);
      check_eq("ch0_reenable_first_tick", d, 8);

      // Random writes against the model
      for (int i = 0; i < 400; i++) begin
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = 2'($urandom_range(0, NCH - 1));
         cfg_jump  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
         cfg_en    = ($urandom_range(0, 3) != 0);
         step();
      end
      cfg_valid = 1'b0;
      wait_ready(n);

      // Reset while a write is pending discards it
      apply_reset();
      write_cfg(1, 32'hC000_0000, 1'b1, 1'b0, w);
      check_eq("pend_before_reset", cfg_ready, 0);
      apply_reset();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tick != 0) cnt++;
      end
      check_eq("discarded_write_no_tick", cnt, 0);

`ifdef PHASE_SYNC_EN
      // Sync realigns phases: ch0 serviced first after sync, ch2 in slot 2
      write_cfg(0, 32'h8000_0000, 1'b1, 1'b0, w);
      wait_ready(n);
      write_cfg(2, 32'h4000_0000, 1'b1, 1'b0, w);
      wait_ready(n);
      repeat (7) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check_eq("sync_tick_cleared", tick, 0);
      begin
         int f0, f2;
         f0 = -1;
         f2 = -1;
         for (int i = 1; i <= 20; i++) begin
            step();
            if (tick[0] && f0 < 0) f0 = i;
            if (tick[2] && f2 < 0) f2 = i;
         end
         check_eq("sync_ch0_first", f0, 1 + NCH);
         check_eq("sync_ch2_first", f2, 3 + 3 * NCH);
      end
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
      $fatal(1);
   end

endmodule
